// File: rtl/raster_setup_queue.sv
// Triangle setup staging, DEPTH-entry commit queue and single-pipeline dispatcher,
// plus registered packing of pipeline pixels into lane-enabled tile-RAM writes.
module raster_setup_queue #(
    parameter int DEPTH        = 4,
    parameter int TILE_BITS    = 5,
    parameter int PIX_PER_WORD = 4,
    parameter int COLOR_W      = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [3:0]                                    reg_addr,
    input  logic [31:0]                                   reg_data,
    input  logic [17:0]                                   reg_float,
    input  logic                                          reg_wren,
    input  logic                                          commit,
    input  logic                                          clear,
    output logic                                          full,
    output logic                                          empty,
    output logic [$clog2(DEPTH):0]                        count,
    output logic                                          overflow,
    output logic                                          busy,
    output logic                                          pipe_start,
    input  logic                                          pipe_done,
    output logic [COLOR_W-1:0]                            s_color,
    output logic [18:0]                                   s_A01,
    output logic [18:0]                                   s_A12,
    output logic [18:0]                                   s_A20,
    output logic [23:0]                                   s_B01,
    output logic [23:0]                                   s_B12,
    output logic [23:0]                                   s_B20,
    output logic [31:0]                                   s_w0,
    output logic [31:0]                                   s_w1,
    output logic [31:0]                                   s_w2,
    output logic [17:0]                                   s_zX,
    output logic [17:0]                                   s_zY,
    output logic [17:0]                                   s_zC,
    output logic                                          s_clear,
    input  logic                                          pix_wren,
    input  logic [TILE_BITS-1:0]                          pix_x,
    input  logic [TILE_BITS-1:0]                          pix_y,
    input  logic [COLOR_W-1:0]                            pix_color,
    output logic [2*TILE_BITS-$clog2(PIX_PER_WORD)-1:0]   addr,
    output logic [PIX_PER_WORD-1:0]                       wren,
    output logic [COLOR_W-1:0]                            data
);

    localparam int PW     = $clog2(DEPTH);
    localparam int LW     = $clog2(PIX_PER_WORD);
    localparam int IDX_W  = 2 * TILE_BITS;
    localparam int ADDR_W = IDX_W - LW;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [18:0]        a01, a12, a20;
        logic [23:0]        b01, b12, b20;
        logic [31:0]        w0, w1, w2;
        logic [17:0]        zx, zy, zc;
    } setup_t;

    typedef struct packed {
        logic   clear;
        setup_t setup;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    setup_t        stg, stg_n;
    entry_t        mem [DEPTH];
    entry_t        s_q;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count_n;
    state_t        state, state_n;
    logic          pop, push, ovf_clr;

    // Staging with this cycle's write folded in, so a same-cycle commit sees it.
    always_comb begin
        stg_n   = stg;
        ovf_clr = 1'b0;
        if (reg_wren) begin
            case (reg_addr)
                4'd0:    stg_n.color = reg_data[COLOR_W-1:0];
                4'd1:    stg_n.a01   = reg_data[18:0];
                4'd2:    stg_n.a12   = reg_data[18:0];
                4'd3:    stg_n.a20   = reg_data[18:0];
                4'd4:    stg_n.b01   = reg_data[23:0];
                4'd5:    stg_n.b12   = reg_data[23:0];
                4'd6:    stg_n.b20   = reg_data[23:0];
                4'd7:    stg_n.w0    = reg_data;
                4'd8:    stg_n.w1    = reg_data;
                4'd9:    stg_n.w2    = reg_data;
                4'd10:   stg_n.zx    = reg_float;
                4'd11:   stg_n.zy    = reg_float;
                4'd12:   stg_n.zc    = reg_float;
                4'd13:   ovf_clr     = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        pipe_start = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                pipe_start = 1'b1;
                state_n    = RUN;
            end
            RUN: begin
                if (pipe_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A full queue still accepts a commit when the dispatcher pops in the same cycle.
    assign push    = commit && (!full || pop);
    assign count_n = count + (PW+1)'(push) - (PW+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            stg      <= '0;
            mem      <= '{default: '0};
            s_q      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            state    <= IDLE;
        end else begin
            stg <= stg_n;
            if (push) begin
                mem[wr_ptr] <= '{clear: clear, setup: stg_n};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                s_q    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_n;
            full  <= (count_n == (PW+1)'(DEPTH));
            empty <= (count_n == '0);
            if (commit && !push)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            state <= state_n;
        end
    end

    assign busy    = !empty || (state != IDLE);
    assign s_color = s_q.setup.color;
    assign s_A01   = s_q.setup.a01;
    assign s_A12   = s_q.setup.a12;
    assign s_A20   = s_q.setup.a20;
    assign s_B01   = s_q.setup.b01;
    assign s_B12   = s_q.setup.b12;
    assign s_B20   = s_q.setup.b20;
    assign s_w0    = s_q.setup.w0;
    assign s_w1    = s_q.setup.w1;
    assign s_w2    = s_q.setup.w2;
    assign s_zX    = s_q.setup.zx;
    assign s_zY    = s_q.setup.zy;
    assign s_zC    = s_q.setup.zc;
    assign s_clear = s_q.clear;

    logic [IDX_W-1:0]        idx;
    logic [PIX_PER_WORD-1:0] wren_n;

    assign idx = {pix_y, pix_x};

    always_comb begin
        wren_n = '0;
        for (int unsigned i = 0; i < PIX_PER_WORD; i++)
            wren_n[i] = pix_wren && ((32'(idx) % 32'(PIX_PER_WORD)) == i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            wren <= '0;
            data <= '0;
        end else begin
            addr <= ADDR_W'(idx >> LW);
            wren <= wren_n;
            data <= pix_color;
        end
    end

endmodule

// File: tb/tb_raster_setup_queue.sv
// Directed/randomized bench for raster_setup_queue: a queue-based model tracks
// committed triangles in FIFO order and each launch is checked against it.
module tb_raster_setup_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  reg_addr;
    logic [31:0] reg_data;
    logic [17:0] reg_float;
    logic        reg_wren, commit, clear;
    logic        full, empty, overflow, busy, pipe_start, pipe_done;
    logic [2:0]  count;
    logic [15:0] s_color;
    logic [18:0] s_A01, s_A12, s_A20;
    logic [23:0] s_B01, s_B12, s_B20;
    logic [31:0] s_w0, s_w1, s_w2;
    logic [17:0] s_zX, s_zY, s_zC;
    logic        s_clear;
    logic        pix_wren;
    logic [4:0]  pix_x, pix_y;
    logic [15:0] pix_color;
    logic [7:0]  addr;
    logic [3:0]  wren;
    logic [15:0] data;

    always #5 clk = ~clk;

    raster_setup_queue #(.DEPTH(4), .TILE_BITS(5), .PIX_PER_WORD(4), .COLOR_W(16)) dut (
        .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_data(reg_data), .reg_float(reg_float),
        .reg_wren(reg_wren), .commit(commit), .clear(clear), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .busy(busy), .pipe_start(pipe_start),
        .pipe_done(pipe_done), .s_color(s_color), .s_A01(s_A01), .s_A12(s_A12), .s_A20(s_A20),
        .s_B01(s_B01), .s_B12(s_B12), .s_B20(s_B20), .s_w0(s_w0), .s_w1(s_w1), .s_w2(s_w2),
        .s_zX(s_zX), .s_zY(s_zY), .s_zC(s_zC), .s_clear(s_clear), .pix_wren(pix_wren),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .addr(addr), .wren(wren), .data(data)
    );

    typedef struct packed {
        logic [15:0] color;
        logic [18:0] a01, a12, a20;
        logic [23:0] b01, b12, b20;
        logic [31:0] w0, w1, w2;
        logic [17:0] zx, zy, zc;
        logic        clr;
    } tri_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    tri_t stg;
    tri_t mq[$];
    int   fill_cnt[6] = '{1, 1, 2, 3, 4, 4};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_setup(tri_t e);
        chk("s_color", s_color, e.color);
        chk("s_A01", s_A01, e.a01);
        chk("s_A12", s_A12, e.a12);
        chk("s_A20", s_A20, e.a20);
        chk("s_B01", s_B01, e.b01);
        chk("s_B12", s_B12, e.b12);
        chk("s_B20", s_B20, e.b20);
        chk("s_w0", s_w0, e.w0);
        chk("s_w1", s_w1, e.w1);
        chk("s_w2", s_w2, e.w2);
        chk("s_zX", s_zX, e.zx);
        chk("s_zY", s_zY, e.zy);
        chk("s_zC", s_zC, e.zc);
        chk("s_clear", s_clear, e.clr);
    endtask

    task automatic chk_reset_state();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", pipe_start, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_s_color", s_color, 0);
        chk("rst_s_A01", s_A01, 0);
        chk("rst_s_w0", s_w0, 0);
        chk("rst_s_clear", s_clear, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wren", wren, 0);
        chk("rst_data", data, 0);
    endtask

    // Drive one register write and apply it to the model staging copy.
    task automatic set_write(int a, logic [31:0] d, logic [17:0] f);
        reg_wren  = 1'b1;
        reg_addr  = a[3:0];
        reg_data  = d;
        reg_float = f;
        case (a)
            0:  stg.color = d[15:0];
            1:  stg.a01 = d[18:0];
            2:  stg.a12 = d[18:0];
            3:  stg.a20 = d[18:0];
            4:  stg.b01 = d[23:0];
            5:  stg.b12 = d[23:0];
            6:  stg.b20 = d[23:0];
            7:  stg.w0 = d;
            8:  stg.w1 = d;
            9:  stg.w2 = d;
            10: stg.zx = f;
            11: stg.zy = f;
            12: stg.zc = f;
            default: ;
        endcase
    endtask

    task automatic idle_bus();
        reg_wren = 1'b0;
        commit   = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic write_all_random();
        for (int a = 0; a < 13; a++) begin
            set_write(a, $urandom, 18'($urandom));
            tick();
        end
        idle_bus();
    endtask

    task automatic commit_with(int a, logic [31:0] d, logic [17:0] f, logic clr, logic accept);
        tri_t e;
        set_write(a, d, f);
        commit = 1'b1;
        clear  = clr;
        if (accept) begin
            e     = stg;
            e.clr = clr;
            mq.push_back(e);
        end
        tick();
        idle_bus();
    endtask

    // Serve every modelled entry: launch contents, single-cycle start, idle gap.
    task automatic serve_all();
        int n;
        n = 0;
        while (pipe_start !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        while (mq.size() > 0) begin
            chk("launch", pipe_start, 1);
            chk_setup(mq.pop_front());
            tick();
            chk("start_one_cycle", pipe_start, 0);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("start_in_run", pipe_start, 0);
            end
            pipe_done = 1'b1;
            tick();
            pipe_done = 1'b0;
            chk("idle_gap", pipe_start, 0);
            tick();
        end
        chk("drained_busy", busy, 0);
        chk("drained_empty", empty, 1);
    endtask

    initial begin
        int idx;
        logic [3:0] exp_wren;
        logic [7:0] exp_addr;
        logic [15:0] exp_data;

        rst = 1'b1; pipe_done = 1'b0; pix_wren = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
        reg_addr = '0; reg_data = '0; reg_float = '0;
        idle_bus();
        stg = '0;
        tick();
        tick();
        chk_reset_state();
        rst = 1'b0;

        // Single triangle, A01 = -3; last field written in the commit cycle.
        set_write(0, 32'h0000_F800, 18'h0); tick();
        set_write(1, 32'hFFFF_FFFD, 18'h0); tick();
        for (int a = 2; a < 12; a++) begin
            set_write(a, $urandom, 18'($urandom));
            tick();
        end
        commit_with(12, $urandom, 18'($urandom), 1'b0, 1'b1);
        chk("t1_count", count, 1);
        chk("t1_empty", empty, 0);
        chk("t1_start_early", pipe_start, 0);
        tick();
        chk("t1_start", pipe_start, 1);
        chk("t1_color", s_color, 16'hF800);
        chk("t1_A01", s_A01, 19'h7FFFD);
        chk_setup(mq.pop_front());
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_start_pulse", pipe_start, 0);
        pipe_done = 1'b1;
        tick();
        pipe_done = 1'b0;
        chk("t1_done_busy", busy, 0);
        chk("t1_done_empty", empty, 1);

        // Fill: 5 accepted (one in flight), the 6th dropped.
        for (int k = 0; k < 6; k++) begin
            commit_with(0, $urandom, 18'h0, 1'($urandom), k < 5);
            chk("fill_count", count, fill_cnt[k]);
            chk("fill_full", full, k >= 4);
            chk("fill_ovf", overflow, k == 5);
        end
        chk_setup(mq.pop_front());
        set_write(13, $urandom, 18'h0);
        tick();
        idle_bus();
        chk("ovf_cleared", overflow, 0);
        chk("ovf_clr_count", count, 4);

        // Commit while full in the same cycle the dispatcher pops.
        pipe_done = 1'b1;
        tick();
        pipe_done = 1'b0;
        chk("pop_idle", pipe_start, 0);
        commit_with(0, $urandom, 18'h0, 1'b1, 1'b1);
        chk("pushpop_count", count, 4);
        chk("pushpop_full", full, 1);
        chk("pushpop_ovf", overflow, 0);
        serve_all();

        // Three distinct triangles queued back-to-back.
        for (int k = 0; k < 3; k++) begin
            write_all_random();
            commit_with(3, $urandom, 18'h0, 1'(k), 1'b1);
        end
        chk_setup(mq.pop_front());
        chk("b2b_run_start", pipe_start, 0);
        pipe_done = 1'b1;
        tick();
        pipe_done = 1'b0;
        chk("b2b_gap", pipe_start, 0);
        tick();
        serve_all();

        // Pixel packing.
        pix_x = 5'd6; pix_y = 5'd1; pix_wren = 1'b1; pix_color = 16'h1234;
        tick();
        chk("pix_addr", addr, 9);
        chk("pix_wren", wren, 4'b0100);
        chk("pix_data", data, 16'h1234);
        pix_wren = 1'b0;
        tick();
        chk("pix_nowren", wren, 0);
        for (int k = 0; k < 24; k++) begin
            pix_x = 5'($urandom); pix_y = 5'($urandom);
            pix_wren = 1'($urandom); pix_color = 16'($urandom);
            idx = int'(pix_y) * 32 + int'(pix_x);
            exp_addr = 8'(idx / 4);
            exp_wren = pix_wren ? 4'(1 << (idx % 4)) : 4'h0;
            exp_data = pix_color;
            tick();
            chk("pix_rand_addr", addr, exp_addr);
            chk("pix_rand_wren", wren, exp_wren);
            chk("pix_rand_data", data, exp_data);
        end

        // Reset while in RUN with two entries queued.
        for (int k = 0; k < 3; k++)
            commit_with(0, $urandom, 18'h0, 1'b1, 1'b1);
        tick();
        chk("prerst_count", count, 2);
        chk("prerst_busy", busy, 1);
        pix_wren = 1'b1; pix_x = 5'd3; pix_y = 5'd7; pix_color = 16'hBEEF;
        rst = 1'b1;
        tick();
        chk_reset_state();
        rst = 1'b0;
        pix_wren = 1'b0;
        stg = '0;
        mq.delete();
        pipe_done = 1'b1;
        tick();
        pipe_done = 1'b0;
        chk("postrst_busy", busy, 0);
        chk("postrst_start", pipe_start, 0);
        tick();
        chk("postrst_idle", pipe_start, 0);
        // Address 14 is ignored, so the committed setup is the reset staging.
        commit_with(14, $urandom, 18'($urandom), 1'b0, 1'b1);
        serve_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/raster_setup_queue.md
# raster_setup_queue

Parametrised front end for the raster pipeline: CPU-written triangle setup registers are staged, committed as whole triangles into a DEPTH-entry queue, and dispatched one at a time to a single raster pipeline via a start/done handshake. It also packs the pipeline's per-pixel output into lane-enabled tile-RAM writes. It sits between the CPU register bus and the tile RAM, so the CPU can set up triangle N+1 while triangle N rasterizes.

## Interface
- DEPTH, 4: queue entries, power of 2, ≥2.
- TILE_BITS, 5: tile is 2^TILE_BITS × 2^TILE_BITS pixels.
- PIX_PER_WORD, 4: pixels per tile-RAM word, power of 2, ≤ 2^TILE_BITS; LW = log2(PIX_PER_WORD).
- COLOR_W, 16: pixel color width.
- Reset is rst, synchronous, active-high; the clock is clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- reg_addr  in  4  setup register select.
- reg_data  in  32  integer write data.
- reg_float  in  18  float write data, used for z registers.
- reg_wren  in  1  register write strobe.
- commit  in  1  push staging snapshot plus clear bit into the queue.
- clear  in  1  clear-mode flag captured with commit.
- full / empty  out  1  queue status.
- count  out  log2(DEPTH)+1  queued entries, excluding the entry in flight.
- overflow  out  1  sticky: a commit was dropped.
- busy  out  1  high when the queue is non-empty or the FSM is not IDLE.
- pipe_start  out  1  one-cycle launch pulse.
- pipe_done  in  1  one-cycle completion pulse from the pipeline.
- s_color COLOR_W, s_A01/s_A12/s_A20 19 signed, s_B01/s_B12/s_B20 24 signed, s_w0/s_w1/s_w2 32 signed, s_zX/s_zY/s_zC 18, s_clear 1  out: setup of the entry in flight.
- pix_wren  in  1  pipeline pixel valid.
- pix_x, pix_y  in  TILE_BITS each  pixel coordinates.
- pix_color  in  COLOR_W  pixel color.
- addr  out  2·TILE_BITS−LW  tile-RAM word address.
- wren  out  PIX_PER_WORD  lane enables.
- data  out  COLOR_W  pixel color to RAM.

## Operation
- Staging register map, written when reg_wren is high:
  - 0: color ← reg_data[COLOR_W−1:0].
  - 1–3: A01, A12, A20 ← reg_data[18:0].
  - 4–6: B01, B12, B20 ← reg_data[23:0].
  - 7–9: w0, w1, w2 ← reg_data.
  - 10–12: zX, zY, zC ← reg_float.
  - 13: clears overflow; data is ignored.
  - 14–15: ignored.
- Staging registers retain their values across commits, so only changed fields need rewriting.
- A reg_wren and a commit in the same cycle: the committed snapshot includes that cycle's write.
- Push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the commit is dropped, overflow is set, and the queue is unchanged.
- Dispatcher FSM:
  - IDLE: when !empty, move to LAUNCH. The head entry is popped into the s_* output register on the transition.
  - LAUNCH: pipe_start=1 for exactly one cycle, then go to RUN.
  - RUN: wait for pipe_done, then go to IDLE. s_* hold stable for the whole of LAUNCH and RUN.
  - pipe_done outside RUN is ignored.
- Back-to-back triangles: at least one IDLE cycle separates pipe_done from the next pipe_start.
- Pixel packing, registered and independent of the FSM:
  - idx = {pix_y, pix_x}.
  - addr ← idx >> LW.
  - wren ← pix_wren ? (1 << idx[LW−1:0]) : 0.
  - data ← pix_color.

## Timing
- Reset values:
  - Staging registers, queue, count = 0; s_* = 0.
  - overflow = 0, pipe_start = 0, busy = 0.
  - empty = 1, full = 0.
  - addr, wren, data = 0.
  - FSM = IDLE.
- Reset mid-triangle flushes the queue and the in-flight entry; the pipeline shares rst.
- Commit at cycle t: count and empty update at t+1.
- From an empty IDLE state, a commit at t gives pipe_start high at t+2, with s_* valid from t+2.
- full and empty are registered; they reflect count after the current cycle's push/pop.
- Pixel path latency is 1 cycle: pix_wren at t gives wren at t+1. Streaming at one pixel per cycle is supported.
- Pointer wrap-around is modulo DEPTH with no bubbles.

## Test plan
- Single triangle: write regs 0–12 (color=16'hF800, A01=−3), commit. Expect pipe_start at t+2 with s_color=F800 and s_A01=−3 (19'h7FFFD); after pipe_done, busy=0 and empty=1.
- Fill: hold pipe_done low and commit DEPTH+1 times (4 queued plus 1 in flight = 5 accepted). The 6th commit sets overflow and count stays 4. A reg write to addr 13 clears overflow.
- Commit while full in the same cycle as the FSM pops: the commit is accepted, count stays 4, and overflow stays 0.
- Three distinct triangles queued back-to-back: each is launched in FIFO order with correct s_* and s_clear. pipe_start is never high while in RUN.
- Pixel packing with TILE_BITS=5, PIX_PER_WORD=4: pix (x=6, y=1) gives addr=9 and wren=4'b0100 one cycle later. With pix_wren=0, wren=0.
- Assert rst while in RUN with 2 entries queued: next cycle all outputs are at reset values, and a subsequent pipe_done is ignored.
